grid_cursor: RTL
================

// Module: grid_cursor
// PURPOSE
//  Parametrised board cursor for a ROWS x COLS tile grid. Buttons move one cell per press.
//  Edges either wrap or clamp. A select button builds a two-tile pair, which is handed to the
//  match checker over a valid/ready handshake.
//  Sits between the debounced button synchroniser and the matcher/renderer.
// PARAMETERS
//  ROWS          6   grid rows, >=2
//  COLS          6   grid columns, >=2
//  WRAP          1   1 = wrap at edges, 0 = clamp at edges
//  REPEAT_DELAY  16  hold cycles before the first auto-repeat (AUTO_REPEAT_EN only), >=1
//  REPEAT_PERIOD 8   cycles between auto-repeats (AUTO_REPEAT_EN only), >=1
// PORTS
//  clk          in   1        clock
//  rst          in   1        reset, asynchronous, active-high
//  up,down      in   1        level buttons, already synchronised/debounced
//  left,right   in   1        level buttons, already synchronised/debounced
//  sel          in   1        level select button
//  pair_ready   in   1        matcher accepts pair
//  cur_bus      out  N        one-hot cursor, N=ROWS*COLS; bit N-1-idx set (MSB = cell 0)
//  cur_row      out  ROW_W    cursor row, ROW_W=$clog2(ROWS)
//  cur_col      out  COL_W    cursor column, COL_W=$clog2(COLS)
//  first_valid  out  1        first tile of a pair is held
//  first_idx    out  IDX_W    held first tile, idx=row*COLS+col, IDX_W=$clog2(N)
//  pair_valid   out  1        pair offered to matcher
//  pair_a       out  IDX_W    first tile of the offered pair
//  pair_b       out  IDX_W    second tile of the offered pair
// BEHAVIOUR
//  Reset: row=col=0, cur_bus=1<<(N-1), first_valid=pair_valid=0, first_idx=pair_a=pair_b=0,
//   all edge/repeat registers 0. Reset mid-operation aborts any pending pair immediately.
//  Press detection: press = btn & ~btn_q (btn_q is btn registered). Row/col update on the same
//   edge that samples the press; outputs are registered, so they are visible 1 cycle after the
//   button rises.
//  Vertical: up&down -> no move; up -> row-1; down -> row+1.
//  Horizontal: left&right -> no move; left -> col-1; right -> col+1.
//  Vertical and horizontal moves apply together in one cycle.
//  Edges: WRAP=1 -> row 0 up -> ROWS-1, col COLS-1 right -> 0, and symmetric cases.
//   WRAP=0 -> the position holds at the edge.
//  cur_bus, cur_row and cur_col are always mutually consistent. cur_bus is combinational from
//   the registered row/col.
//  Select FSM (registered; sel uses press detection):
//   IDLE  : sel -> ONE; latch first_idx=cur idx; first_valid=1.
//   ONE   : sel on same idx -> IDLE (cancel, first_valid=0).
//           sel on other idx -> PAIR; pair_a=first_idx, pair_b=cur idx, pair_valid=1.
//   PAIR  : pair_a/pair_b stable and sel ignored while pair_valid & ~pair_ready.
//           pair_valid & pair_ready -> IDLE; pair_valid and first_valid drop next cycle.
//  The cursor keeps moving in every FSM state. A move and a sel press in the same cycle: sel
//   uses the pre-move idx.
// CONFIGURATION
//  AUTO_REPEAT_EN defined: per direction, a held button with opposite not held generates a
//   press at the rising edge. It generates another after REPEAT_DELAY held cycles, then one
//   every REPEAT_PERIOD cycles. Release, or opposite button asserted, clears the counter.
//  AUTO_REPEAT_EN undefined: one move per press only; REPEAT_* parameters are unused; no
//   counters are instantiated.
// STRUCTURE
//  Package grid_cursor_pkg: sel_state_t enum {IDLE, ONE, PAIR}, default ROWS/COLS, and the
//   IDX_W/ROW_W/COL_W width functions.
//  Sub-module key_repeat (one per direction): edge detect plus optional repeat counter;
//   output is a 1-cycle step pulse.
//  Top level: row/col step logic, wrap/clamp logic, select FSM, one-hot decode.
// TESTING (ROWS=COLS=6 unless noted)
//  1 Reset with buttons low -> idx 0, cur_bus=36'h8_0000_0000, first_valid=pair_valid=0.
//  2 WRAP=1: up press at (0,0) -> (5,0), idx 30, cur_bus bit 5.
//    Then left press -> (5,5), idx 35, cur_bus bit 0.
//  3 WRAP=0: up at (0,0) -> stays idx 0. right held 20 cycles, no macro -> exactly 1 move,
//    idx 1.
//  4 From (2,2): up+right pressed the same cycle -> (1,3), idx 9, 1 cycle later.
//    up+down together -> row unchanged.
//  5 sel at idx 0, right, sel -> pair_valid=1, pair_a=0, pair_b=1. Hold pair_ready=0 5 cycles
//    with sel pulses -> outputs stable. pair_ready=1 -> IDLE next cycle.
//    Separately: sel, sel same cell -> cancel.
//  6 AUTO_REPEAT_EN, REPEAT_DELAY=4, REPEAT_PERIOD=2, WRAP=1: right held 11 cycles from idx 0
//    -> steps at held cycles 0,4,6,8,10 -> idx 5. Assert rst mid-hold -> idx 0 immediately.

Source files
------------

// File: rtl/grid_cursor_pkg.sv
// Shared types and width helpers for the grid cursor block.
package grid_cursor_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ONE  = 2'd1,
        PAIR = 2'd2
    } sel_state_t;

    localparam int DEF_ROWS = 6;
    localparam int DEF_COLS = 6;

    function automatic int idx_w(input int rows, input int cols);
        return $clog2(rows * cols);
    endfunction

    function automatic int row_w(input int rows);
        return $clog2(rows);
    endfunction

    function automatic int col_w(input int cols);
        return $clog2(cols);
    endfunction

endpackage

// File: rtl/grid_cursor_if.sv
// Tile-pair handshake from the cursor to the match checker.
interface grid_cursor_if
    import grid_cursor_pkg::*;
#(
    parameter int IDX_W = idx_w(DEF_ROWS, DEF_COLS)
) ();

    logic             pair_valid;
    logic             pair_ready;
    logic [IDX_W-1:0] pair_a;
    logic [IDX_W-1:0] pair_b;

    modport master (output pair_valid, output pair_a, output pair_b, input pair_ready);
    modport slave  (input pair_valid, input pair_a, input pair_b, output pair_ready);

endinterface

// File: rtl/grid_cursor_key_repeat.sv
// Per-direction press detector; with AUTO_REPEAT_EN defined it also auto-repeats
// a held button (opposite button not held) after REPEAT_DELAY, then every REPEAT_PERIOD.
module key_repeat #(
    parameter int REPEAT_DELAY  = 16,
    parameter int REPEAT_PERIOD = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic btn,
`ifdef AUTO_REPEAT_EN
    input  logic opp,
`endif
    output logic step
);

    logic btn_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) btn_q <= 1'b0;
        else     btn_q <= btn;
    end

`ifdef AUTO_REPEAT_EN
    localparam int CNT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_nxt;
    logic             active;
    logic             rise;
    logic             tc;

    // cnt_q==0 means disarmed; a repeat fires when the counter reaches 1.
    assign active = btn & ~opp;
    assign rise   = btn & ~btn_q;
    assign tc     = active & (cnt_q == CNT_W'(1));
    assign step   = (active & rise) | tc;

    always_comb begin
        cnt_nxt = cnt_q;
        if (!active)             cnt_nxt = '0;
        else if (rise)           cnt_nxt = CNT_W'(REPEAT_DELAY);
        else if (tc)             cnt_nxt = CNT_W'(REPEAT_PERIOD);
        else if (cnt_q != '0)    cnt_nxt = cnt_q - CNT_W'(1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_nxt;
    end
`else
    assign step = btn & ~btn_q;
`endif

    if (REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_bad_repeat
        $error("key_repeat: REPEAT_DELAY and REPEAT_PERIOD must be >= 1");
    end

endmodule

// File: rtl/grid_cursor.sv
// Board cursor for a ROWS x COLS grid with wrap/clamp edges and a two-tile select FSM.
// Define AUTO_REPEAT_EN to enable auto-repeat on held direction buttons.
module grid_cursor
    import grid_cursor_pkg::*;
#(
    parameter int  ROWS          = DEF_ROWS,
    parameter int  COLS          = DEF_COLS,
    parameter bit  WRAP          = 1'b1,
    parameter int  REPEAT_DELAY  = 16,
    parameter int  REPEAT_PERIOD = 8,
    localparam int N             = ROWS * COLS,
    localparam int ROW_W         = row_w(ROWS),
    localparam int COL_W         = col_w(COLS),
    localparam int IDX_W         = idx_w(ROWS, COLS)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               up,
    input  logic               down,
    input  logic               left,
    input  logic               right,
    input  logic               sel,
    grid_cursor_if.master      pair_if,
    output logic [N-1:0]       cur_bus,
    output logic [ROW_W-1:0]   cur_row,
    output logic [COL_W-1:0]   cur_col,
    output logic               first_valid,
    output logic [IDX_W-1:0]   first_idx
);

    localparam logic [ROW_W-1:0] ROW_LAST   = ROW_W'(ROWS - 1);
    localparam logic [COL_W-1:0] COL_LAST   = COL_W'(COLS - 1);
    localparam logic [N-1:0]     ONEHOT_MSB = {1'b1, {(N-1){1'b0}}};

    if (ROWS < 2 || COLS < 2) begin : g_bad_size
        $error("grid_cursor: ROWS and COLS must be >= 2");
    end

    logic up_step, down_step, left_step, right_step;

    key_repeat #(.REPEAT_DELAY(REPEAT_DELAY), .REPEAT_PERIOD(REPEAT_PERIOD)) u_up (
        .clk  (clk),
        .rst  (rst),
        .btn  (up),
`ifdef AUTO_REPEAT_EN
        .opp  (down),
`endif
        .step (up_step)
    );

    key_repeat #(.REPEAT_DELAY(REPEAT_DELAY), .REPEAT_PERIOD(REPEAT_PERIOD)) u_down (
        .clk  (clk),
        .rst  (rst),
        .btn  (down),
`ifdef AUTO_REPEAT_EN
        .opp  (up),
`endif
        .step (down_step)
    );

    key_repeat #(.REPEAT_DELAY(REPEAT_DELAY), .REPEAT_PERIOD(REPEAT_PERIOD)) u_left (
        .clk  (clk),
        .rst  (rst),
        .btn  (left),
`ifdef AUTO_REPEAT_EN
        .opp  (right),
`endif
        .step (left_step)
    );

    key_repeat #(.REPEAT_DELAY(REPEAT_DELAY), .REPEAT_PERIOD(REPEAT_PERIOD)) u_right (
        .clk  (clk),
        .rst  (rst),
        .btn  (right),
`ifdef AUTO_REPEAT_EN
        .opp  (left),
`endif
        .step (right_step)
    );

    logic [ROW_W-1:0] row_q, row_nxt;
    logic [COL_W-1:0] col_q, col_nxt;
    logic [IDX_W-1:0] cur_idx;

    // Opposite steps in the same cycle cancel; vertical and horizontal are independent.
    always_comb begin
        row_nxt = row_q;
        if (up_step && !down_step) begin
            if (row_q != '0)   row_nxt = row_q - ROW_W'(1);
            else if (WRAP)     row_nxt = ROW_LAST;
        end else if (down_step && !up_step) begin
            if (row_q != ROW_LAST) row_nxt = row_q + ROW_W'(1);
            else if (WRAP)         row_nxt = '0;
        end
    end

    always_comb begin
        col_nxt = col_q;
        if (left_step && !right_step) begin
            if (col_q != '0)   col_nxt = col_q - COL_W'(1);
            else if (WRAP)     col_nxt = COL_LAST;
        end else if (right_step && !left_step) begin
            if (col_q != COL_LAST) col_nxt = col_q + COL_W'(1);
            else if (WRAP)         col_nxt = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            row_q <= '0;
            col_q <= '0;
        end else begin
            row_q <= row_nxt;
            col_q <= col_nxt;
        end
    end

    assign cur_idx = IDX_W'(row_q) * IDX_W'(COLS) + IDX_W'(col_q);
    assign cur_bus = ONEHOT_MSB >> cur_idx;
    assign cur_row = row_q;
    assign cur_col = col_q;

    logic             sel_q;
    logic             sel_press;
    sel_state_t       state_q, state_nxt;
    logic [IDX_W-1:0] first_q, first_nxt;
    logic [IDX_W-1:0] a_q, a_nxt;
    logic [IDX_W-1:0] b_q, b_nxt;

    assign sel_press = sel & ~sel_q;

    // cur_idx is the registered position, so a same-cycle move never affects sel.
    always_comb begin
        state_nxt = state_q;
        first_nxt = first_q;
        a_nxt     = a_q;
        b_nxt     = b_q;
        case (state_q)
            IDLE: begin
                if (sel_press) begin
                    state_nxt = ONE;
                    first_nxt = cur_idx;
                end
            end
            ONE: begin
                if (sel_press) begin
                    if (cur_idx == first_q) begin
                        state_nxt = IDLE;
                    end else begin
                        state_nxt = PAIR;
                        a_nxt     = first_q;
                        b_nxt     = cur_idx;
                    end
                end
            end
            PAIR: begin
                if (pair_if.pair_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sel_q   <= 1'b0;
            state_q <= IDLE;
            first_q <= '0;
            a_q     <= '0;
            b_q     <= '0;
        end else begin
            sel_q   <= sel;
            state_q <= state_nxt;
            first_q <= first_nxt;
            a_q     <= a_nxt;
            b_q     <= b_nxt;
        end
    end

    assign first_valid        = (state_q != IDLE);
    assign first_idx          = first_q;
    assign pair_if.pair_valid = (state_q == PAIR);
    assign pair_if.pair_a     = a_q;
    assign pair_if.pair_b     = b_q;

endmodule
